exc_ctrl: RTL and testbench

Exception/interrupt controller that sequences the EPC register and the PC redirect path of the MIPS core. It arbitrates synchronous exceptions (reserved instruction, overflow, syscall) and masked external interrupts, and drives the EPC write enable and data. It also holds the Status and Cause registers and handles `eret` by redirecting fetch to the saved EPC. It sits beside the commit stage, between the decode/ALU exception flags and the PC/EPC registers.

---
 rtl/cp0_pkg.sv | 27 ++
 rtl/exc_prio_enc.sv | 33 +++
 rtl/exc_ctrl.sv | 153 +++++++++++++++
 tb/tb_exc_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, Status/Cause field positions,
// exception-controller state encoding and the default handler vector.
package cp0_pkg;

    localparam int EXCCODE_W = 5;

    localparam logic [EXCCODE_W-1:0] EXC_INT = 5'd0;
    localparam logic [EXCCODE_W-1:0] EXC_SYS = 5'd8;
    localparam logic [EXCCODE_W-1:0] EXC_RI  = 5'd10;
    localparam logic [EXCCODE_W-1:0] EXC_OV  = 5'd12;

    // Status: IE at bit 0, EXL at bit 1, IM starting at bit 10.
    // Cause:  ExcCode at bits [6:2], IP starting at bit 10.
    localparam int ST_IE_BIT   = 0;
    localparam int ST_EXL_BIT  = 1;
    localparam int IM_LSB      = 10;
    localparam int EXCCODE_LSB = 2;

    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0180;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TAKE = 2'd1,
        RET  = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder: RI > Ov > Sys > interrupt.
// Inputs are expected to be pre-qualified (instr_valid, IE/EXL/IM masking).
module exc_prio_enc
    import cp0_pkg::*;
#(
    parameter int NUM_IRQ = 6
) (
    input  logic                 i_ri,
    input  logic                 i_ovf,
    input  logic                 i_sys,
    input  logic [NUM_IRQ-1:0]   i_irq_masked,
    output logic                 o_valid,
    output logic [EXCCODE_W-1:0] o_code
);

    // Fixed-priority selection; any interrupt line maps to the single Int code.
    always_comb begin
        o_valid = 1'b1;
        o_code  = EXC_INT;
        if (i_ri) begin
            o_code = EXC_RI;
        end else if (i_ovf) begin
            o_code = EXC_OV;
        end else if (i_sys) begin
            o_code = EXC_SYS;
        end else if (|i_irq_masked) begin
            o_code = EXC_INT;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: detects events at commit, sequences the
// one-cycle TAKE (vector + EPC write) and RET (eret redirect) states, and
// holds the Status and Cause registers.
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ      = 6,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        pc_cur,
    input  logic               exc_ri,
    input  logic               exc_ovf,
    input  logic               exc_sys,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mtc0_we,
    input  logic               mtc0_sel,
    input  logic [31:0]        mtc0_data,
    input  logic [31:0]        epc_q,
    output logic               epc_we,
    output logic [31:0]        epc_din,
    output logic               flush,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        status,
    output logic [31:0]        cause,
    output logic               in_handler
);

    exc_state_t           r_state;
    logic [NUM_IRQ-1:0]   r_im;
    logic                 r_exl;
    logic                 r_ie;
    logic [EXCCODE_W-1:0] r_exccode;
    logic [EXCCODE_W-1:0] r_code_lat;
    logic [31:0]          r_pc_lat;
    logic                 r_epc_we;
    logic                 r_redirect;

    logic                 w_run;
    logic [NUM_IRQ-1:0]   w_irq_masked;
    logic                 w_exc;
    logic [EXCCODE_W-1:0] w_code;
    logic                 w_eret;
    logic                 w_mtc0;
    logic                 w_unused;

    assign w_run        = (r_state == RUN);
    assign w_irq_masked = (instr_valid && r_ie && !r_exl) ? (irq & r_im) : '0;

    exc_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .i_ri         (instr_valid & exc_ri),
        .i_ovf        (instr_valid & exc_ovf),
        .i_sys        (instr_valid & exc_sys),
        .i_irq_masked (w_irq_masked),
        .o_valid      (w_exc),
        .o_code       (w_code)
    );

    // eret and mtc0 only act when no exception claims the same commit slot.
    assign w_eret = instr_valid && eret && !w_exc;
    assign w_mtc0 = instr_valid && mtc0_we && !w_exc;

    // Only some mtc0_data bits land in a register; the rest are don't-care.
    assign w_unused = &{1'b0, mtc0_data};

    // Controller FSM plus CP0 register updates; TAKE and RET ignore inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_exccode  <= EXC_INT;
            r_code_lat <= EXC_INT;
            r_pc_lat   <= '0;
            r_epc_we   <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_exc) begin
                        r_state    <= TAKE;
                        r_pc_lat   <= pc_cur;
                        r_code_lat <= w_code;
                        r_epc_we   <= !r_exl;
                        r_redirect <= 1'b1;
                    end else if (w_eret) begin
                        r_state    <= RET;
                        r_redirect <= 1'b1;
                    end else if (w_mtc0) begin
                        if (mtc0_sel) begin
                            r_exccode <= mtc0_data[EXCCODE_LSB +: EXCCODE_W];
                        end else begin
                            r_im  <= mtc0_data[IM_LSB +: NUM_IRQ];
                            r_exl <= mtc0_data[ST_EXL_BIT];
                            r_ie  <= mtc0_data[ST_IE_BIT];
                        end
                    end
                end
                TAKE: begin
                    r_exccode  <= r_code_lat;
                    r_exl      <= 1'b1;
                    r_epc_we   <= 1'b0;
                    r_redirect <= 1'b0;
                    r_state    <= RUN;
                end
                RET: begin
                    r_exl      <= 1'b0;
                    r_redirect <= 1'b0;
                    r_state    <= RUN;
                end
                default: begin
                    r_epc_we   <= 1'b0;
                    r_redirect <= 1'b0;
                    r_state    <= RUN;
                end
            endcase
        end
    end

    // Redirect target and EPC data are driven only while their strobes are high.
    always_comb begin
        flush       = w_run && (w_exc || w_eret);
        epc_we      = r_epc_we;
        epc_din     = r_epc_we ? r_pc_lat : 32'h0;
        redirect    = r_redirect;
        redirect_pc = 32'h0;
        if (r_state == TAKE) begin
            redirect_pc = HANDLER_ADDR;
        end else if (r_state == RET) begin
            redirect_pc = epc_q;
        end
    end

    // Architectural view of Status and Cause; unimplemented bits read as 0.
    always_comb begin
        status                              = '0;
        status[IM_LSB +: NUM_IRQ]           = r_im;
        status[ST_EXL_BIT]                  = r_exl;
        status[ST_IE_BIT]                   = r_ie;
        cause                               = '0;
        cause[IM_LSB +: NUM_IRQ]            = irq;
        cause[EXCCODE_LSB +: EXCCODE_W]     = r_exccode;
        in_handler                          = r_exl;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: exception entry, interrupt masking, priority,
// nested sync exception, eret, mtc0 interaction and reset during TAKE.
module tb_exc_ctrl;

    localparam int NUM_IRQ = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               instr_valid;
    logic [31:0]        pc_cur;
    logic               exc_ri, exc_ovf, exc_sys, eret;
    logic [NUM_IRQ-1:0] irq;
    logic               mtc0_we, mtc0_sel;
    logic [31:0]        mtc0_data;
    logic [31:0]        epc_q;
    logic               epc_we;
    logic [31:0]        epc_din;
    logic               flush, redirect;
    logic [31:0]        redirect_pc, status, cause;
    logic               in_handler;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(
        .NUM_IRQ      (NUM_IRQ),
        .HANDLER_ADDR (32'h0000_0180)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pc_cur      (pc_cur),
        .exc_ri      (exc_ri),
        .exc_ovf     (exc_ovf),
        .exc_sys     (exc_sys),
        .eret        (eret),
        .irq         (irq),
        .mtc0_we     (mtc0_we),
        .mtc0_sel    (mtc0_sel),
        .mtc0_data   (mtc0_data),
        .epc_q       (epc_q),
        .epc_we      (epc_we),
        .epc_din     (epc_din),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .status      (status),
        .cause       (cause),
        .in_handler  (in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Move from the drive point to mid-cycle for sampling.
    task automatic settle;
        #3;
    endtask

    task automatic idle_in;
        instr_valid = 1'b0;
        pc_cur      = 32'h0;
        exc_ri      = 1'b0;
        exc_ovf     = 1'b0;
        exc_sys     = 1'b0;
        eret        = 1'b0;
        mtc0_we     = 1'b0;
        mtc0_sel    = 1'b0;
        mtc0_data   = 32'h0;
    endtask

    task automatic wr_status(input logic [31:0] val);
        idle_in();
        instr_valid = 1'b1;
        mtc0_we     = 1'b1;
        mtc0_sel    = 1'b0;
        mtc0_data   = val;
        tick();
        idle_in();
    endtask

    initial begin
        rst   = 1'b1;
        irq   = '0;
        epc_q = 32'h0000_2000;
        idle_in();
        tick();
        tick();
        settle();
        chk("rst_status",   status,      32'h0);
        chk("rst_cause",    cause,       32'h0);
        chk("rst_epc_we",   epc_we,      32'h0);
        chk("rst_redirect", redirect,    32'h0);
        chk("rst_rpc",      redirect_pc, 32'h0);
        tick();
        rst = 1'b0;

        // Overflow entry from RUN with EXL = 0.
        instr_valid = 1'b1; pc_cur = 32'h40; exc_ovf = 1'b1;
        settle();
        chk("ovf_flush_N",    flush,    32'h1);
        chk("ovf_redirect_N", redirect, 32'h0);
        tick(); idle_in(); settle();
        chk("ovf_epc_we",  epc_we,      32'h1);
        chk("ovf_epc_din", epc_din,     32'h40);
        chk("ovf_redir",   redirect,    32'h1);
        chk("ovf_rpc",     redirect_pc, 32'h180);
        chk("ovf_flush1",  flush,       32'h0);
        tick(); settle();
        chk("ovf_code",    cause,       32'h30);
        chk("ovf_status",  status,      32'h2);
        chk("ovf_inh",     in_handler,  32'h1);
        chk("ovf_epc_off", epc_we,      32'h0);

        // Interrupt entry with IM0 and IE set; irq drops after detection.
        wr_status(32'h401);
        settle();
        chk("st_401", status, 32'h401);
        tick();
        instr_valid = 1'b1; pc_cur = 32'h100; irq = 6'b000001;
        settle();
        chk("int_flush", flush, 32'h1);
        tick(); idle_in(); irq = '0; settle();
        chk("int_epc_we",  epc_we,      32'h1);
        chk("int_epc_din", epc_din,     32'h100);
        chk("int_rpc",     redirect_pc, 32'h180);
        tick(); settle();
        chk("int_cause",   cause,       32'h0);
        chk("int_status",  status,      32'h403);

        // IE = 0 masks the interrupt entirely.
        wr_status(32'h400);
        instr_valid = 1'b1; pc_cur = 32'h104; irq = 6'b000001;
        settle();
        chk("noie_flush", flush, 32'h0);
        chk("noie_ip",    cause, 32'h400);
        tick(); idle_in(); irq = '0; settle();
        chk("noie_redir", redirect, 32'h0);

        // RI beats Sys; then Sys with EXL = 1 vectors without writing EPC.
        instr_valid = 1'b1; pc_cur = 32'h200; exc_ri = 1'b1; exc_sys = 1'b1;
        settle();
        chk("ri_flush", flush, 32'h1);
        tick(); idle_in(); settle();
        chk("ri_epc_din", epc_din, 32'h200);
        tick(); settle();
        chk("ri_code",   cause,  32'h28);
        chk("ri_status", status, 32'h402);
        instr_valid = 1'b1; pc_cur = 32'h300; exc_sys = 1'b1;
        settle();
        chk("sys_flush", flush, 32'h1);
        tick(); idle_in(); settle();
        chk("sys_redir",   redirect,    32'h1);
        chk("sys_rpc",     redirect_pc, 32'h180);
        chk("sys_epc_we",  epc_we,      32'h0);
        chk("sys_epc_din", epc_din,     32'h0);
        tick(); settle();
        chk("sys_code", cause, 32'h20);

        // eret with a pending-but-masked-by-EXL irq; irq taken after EXL clears.
        wr_status(32'h403);
        irq = 6'b000001;
        instr_valid = 1'b1; eret = 1'b1; pc_cur = 32'h404;
        settle();
        chk("eret_flush", flush, 32'h1);
        tick(); eret = 1'b0; pc_cur = 32'h408; settle();
        chk("ret_redir", redirect,    32'h1);
        chk("ret_rpc",   redirect_pc, 32'h2000);
        chk("ret_flush", flush,       32'h0);
        chk("ret_epcwe", epc_we,      32'h0);
        tick(); pc_cur = 32'h500; settle();
        chk("ret_status",  status, 32'h401);
        chk("post_int_fl", flush,  32'h1);
        tick(); idle_in(); irq = '0; settle();
        chk("post_int_din", epc_din, 32'h500);
        tick(); settle();
        chk("post_int_st", status, 32'h403);

        // mtc0 alongside an exception is dropped; reset during TAKE.
        wr_status(32'h400);
        instr_valid = 1'b1; pc_cur = 32'h600; exc_ovf = 1'b1;
        mtc0_we = 1'b1; mtc0_sel = 1'b0; mtc0_data = 32'h1;
        settle();
        chk("mt_flush", flush, 32'h1);
        tick(); idle_in(); settle();
        chk("mt_epc_we", epc_we, 32'h1);
        chk("mt_ie",     status, 32'h400);
        rst = 1'b1;
        #1;
        chk("arst_epc_we", epc_we,      32'h0);
        chk("arst_status", status,      32'h0);
        chk("arst_redir",  redirect,    32'h0);
        chk("arst_rpc",    redirect_pc, 32'h0);
        chk("arst_cause",  cause,       32'h0);
        tick();
        rst = 1'b0;

        // Exception and eret together: exception wins, EXL stays set.
        instr_valid = 1'b1; pc_cur = 32'h700; eret = 1'b1; exc_sys = 1'b1;
        settle();
        chk("both_flush", flush, 32'h1);
        tick(); idle_in(); settle();
        chk("both_rpc",   redirect_pc, 32'h180);
        chk("both_epcwe", epc_we,      32'h1);
        tick(); settle();
        chk("both_status", status, 32'h2);
        chk("both_code",   cause,  32'h20);

        // Cause write touches only ExcCode.
        instr_valid = 1'b1; mtc0_we = 1'b1; mtc0_sel = 1'b1; mtc0_data = 32'hFFFF_FFFF;
        tick(); idle_in(); settle();
        chk("cause_wr", cause, 32'h7C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
